// File: rtl/spu_event_receiver_pkg.sv
// Shared types and constants for the SPU event receiver.
package spu_event_receiver_pkg;

    // Window FSM states; encodings are visible on state_o and in the status word.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } spu_state_e;

    // Privilege field encodings carried in e_info.
    localparam logic [1:0] PRIV_INV = 2'b00;
    localparam logic [1:0] PRIV_M   = 2'b01;
    localparam logic [1:0] PRIV_S   = 2'b10;
    localparam logic [1:0] PRIV_U   = 2'b11;

    // PC-match tag meanings.
    localparam logic [1:0] PC_TAG_START = 2'd0;
    localparam logic [1:0] PC_TAG_STOP  = 2'd1;
    localparam logic [1:0] PC_TAG_SNAP0 = 2'd2;
    localparam logic [1:0] PC_TAG_SNAP1 = 2'd3;

    // Read map: rd_addr[3:2] selects the region, rd_addr[1:0] the counter index.
    localparam logic [1:0] RD_ADDR_CNT    = 2'd0;
    localparam logic [1:0] RD_ADDR_SNAP0  = 2'd1;
    localparam logic [1:0] RD_ADDR_SNAP1  = 2'd2;
    localparam logic [1:0] RD_ADDR_MISC   = 2'd3;
    localparam logic [3:0] RD_ADDR_STATUS = 4'd12;

    // Status word layout, packed from the LSB.
    localparam int unsigned STAT_STATE_LSB = 0;
    localparam int unsigned STAT_OVF_LSB   = 2;

    function automatic int unsigned stat_irq_bit(input int unsigned num_events);
        return STAT_OVF_LSB + num_events;
    endfunction

endpackage

// File: rtl/spu_event_receiver_if.sv
// Event stream and read port between the EVU side and the SPU event receiver.
interface spu_event_receiver_if #(
    parameter int unsigned NUM_EVENTS = 4,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned ASID_WIDTH = 16
);
    logic [NUM_EVENTS:0]     e_id_i;
    logic [ASID_WIDTH+3:0]   e_info_i;
    logic                    rd_req_i;
    logic [3:0]              rd_addr_i;
    logic                    rd_valid_o;
    logic [CNT_WIDTH-1:0]    rd_data_o;

    modport master (
        output e_id_i, e_info_i, rd_req_i, rd_addr_i,
        input  rd_valid_o, rd_data_o
    );

    modport slave (
        input  e_id_i, e_info_i, rd_req_i, rd_addr_i,
        output rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/spu_event_receiver_evt_counter.sv
// One wrapping event counter with synchronous clear and a sticky overflow flag.
module spu_evt_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic [CNT_WIDTH-1:0] cnt_next_o,
    output logic                 ovf_o
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // Next value: clear beats increment; wrapping from all-ones sets the sticky flag.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign ovf_o      = ovf_q;
endmodule

// File: rtl/spu_event_receiver.sv
// SPU-side receiver for the EVU event stream: filters, counts, windows and snapshots events.
module spu_event_receiver
    import spu_event_receiver_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 4,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned ASID_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spu_event_receiver_if.slave   bus,
    input  logic                  mode_i,
    input  logic [NUM_EVENTS-1:0] cnt_en_i,
    input  logic [2:0]            priv_mask_i,
    input  logic                  asid_flt_en_i,
    input  logic [ASID_WIDTH-1:0] asid_match_i,
    input  logic                  arm_i,
    input  logic                  clear_i,
    input  logic                  irq_en_i,
    output logic [1:0]            state_o,
    output logic [NUM_EVENTS-1:0] ovf_o,
    output logic                  irq_o
);
    localparam int unsigned STAT_W = NUM_EVENTS + 3;

    logic [NUM_EVENTS:0]   s1_id_q;
    logic [ASID_WIDTH+3:0] s1_info_q;

    logic                  pc_match;
    logic [NUM_EVENTS-1:0] ev;
    logic [ASID_WIDTH-1:0] asid;
    logic [1:0]            priv;
    logic [1:0]            pc_tag;
    logic                  priv_ok, asid_ok, gate;
    logic [NUM_EVENTS-1:0] inc;
    logic                  cnt_clr;
    logic                  snap_ok;

    spu_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0] cnt     [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] cnt_nxt [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] snap0_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] snap1_q [NUM_EVENTS];

    logic [STAT_W-1:0]    stat_word;
    logic [CNT_WIDTH-1:0] rd_word;
    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;

    // Stage 1: capture the event stream every cycle; reset discards in-flight data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_id_q   <= '0;
            s1_info_q <= '0;
        end else begin
            s1_id_q   <= bus.e_id_i;
            s1_info_q <= bus.e_info_i;
        end
    end

    assign pc_match = s1_id_q[NUM_EVENTS];
    assign ev       = s1_id_q[NUM_EVENTS-1:0];
    assign asid     = s1_info_q[ASID_WIDTH-1:0];
    assign priv     = s1_info_q[ASID_WIDTH +: 2];
    assign pc_tag   = s1_info_q[ASID_WIDTH+2 +: 2];

    // Qualification of the registered beat: privilege, ASID and window gate.
    always_comb begin
        priv_ok = 1'b0;
        case (priv)
            PRIV_M:  priv_ok = priv_mask_i[0];
            PRIV_S:  priv_ok = priv_mask_i[1];
            PRIV_U:  priv_ok = priv_mask_i[2];
            default: priv_ok = 1'b0;
        endcase
        asid_ok = !asid_flt_en_i || (asid == asid_match_i);
        // The start beat itself is counted, so ARMED opens the gate on a tag-0 match.
        gate = !mode_i || (state_q == StRun) ||
               ((state_q == StArmed) && pc_match && (pc_tag == PC_TAG_START));
        inc  = ev & cnt_en_i & {NUM_EVENTS{priv_ok & asid_ok & gate}};
    end

    assign cnt_clr = clear_i | arm_i;

    // Window FSM next state; clear outranks arm, both outrank tag transitions.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else if (arm_i) begin
            state_d = StArmed;
        end else begin
            case (state_q)
                StArmed: if (pc_match && pc_tag == PC_TAG_START) state_d = StRun;
                StRun:   if (pc_match && pc_tag == PC_TAG_STOP)  state_d = StDone;
                default: state_d = state_q;
            endcase
        end
    end

    // Window FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cnt
        spu_evt_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (cnt_clr),
            .inc_i      (inc[i]),
            .cnt_o      (cnt[i]),
            .cnt_next_o (cnt_nxt[i]),
            .ovf_o      (ovf_o[i])
        );
    end

    assign snap_ok = pc_match && ((state_q == StRun) || !mode_i) && !clear_i && !arm_i;

    // Snapshot banks capture post-increment counters; only clear_i wipes them.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                snap0_q[i] <= '0;
                snap1_q[i] <= '0;
            end
        end else if (snap_ok && pc_tag == PC_TAG_SNAP0) begin
            snap0_q <= cnt_nxt;
        end else if (snap_ok && pc_tag == PC_TAG_SNAP1) begin
            snap1_q <= cnt_nxt;
        end
    end

    assign state_o = state_q;
    assign irq_o   = irq_en_i & (|ovf_o);

    // Read mux over current (pre-update) register values.
    always_comb begin
        rd_word   = '0;
        stat_word = '0;
        stat_word[STAT_STATE_LSB +: 2]           = state_o;
        stat_word[STAT_OVF_LSB +: NUM_EVENTS]    = ovf_o;
        stat_word[stat_irq_bit(NUM_EVENTS)]      = irq_o;
        case (bus.rd_addr_i[3:2])
            RD_ADDR_CNT: begin
                if (32'(bus.rd_addr_i[1:0]) < NUM_EVENTS) rd_word = cnt[bus.rd_addr_i[1:0]];
            end
            RD_ADDR_SNAP0: begin
                if (32'(bus.rd_addr_i[1:0]) < NUM_EVENTS) rd_word = snap0_q[bus.rd_addr_i[1:0]];
            end
            RD_ADDR_SNAP1: begin
                if (32'(bus.rd_addr_i[1:0]) < NUM_EVENTS) rd_word = snap1_q[bus.rd_addr_i[1:0]];
            end
            default: begin
                if (bus.rd_addr_i == RD_ADDR_STATUS) rd_word = CNT_WIDTH'(stat_word);
            end
        endcase
    end

    // Registered read port; data holds between requests.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_req_i;
            if (bus.rd_req_i) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
endmodule

// File: tb/tb_spu_event_receiver.sv
// Directed bench: a 32-bit instance for general behaviour and a 4-bit one for overflow.
module tb_spu_event_receiver;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  e_id;
    logic [19:0] e_info;
    logic        mode, asid_flt_en, arm, clear, rd_req, irq_en;
    logic [3:0]  cnt_en, rd_addr;
    logic [2:0]  priv_mask;
    logic [15:0] asid_match;
    logic [1:0]  state32, state4;
    logic [3:0]  ovf32, ovf4;
    logic        irq32, irq4;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdat32;
    logic [31:0] rdat4;
    logic        rvld;

    always #5 clk = ~clk;

    spu_event_receiver_if #(.NUM_EVENTS(4), .CNT_WIDTH(32), .ASID_WIDTH(16)) bus32 ();
    spu_event_receiver_if #(.NUM_EVENTS(4), .CNT_WIDTH(4),  .ASID_WIDTH(16)) bus4 ();

    assign bus32.e_id_i    = e_id;
    assign bus32.e_info_i  = e_info;
    assign bus32.rd_req_i  = rd_req;
    assign bus32.rd_addr_i = rd_addr;
    assign bus4.e_id_i     = e_id;
    assign bus4.e_info_i   = e_info;
    assign bus4.rd_req_i   = rd_req;
    assign bus4.rd_addr_i  = rd_addr;

    spu_event_receiver #(.NUM_EVENTS(4), .CNT_WIDTH(32), .ASID_WIDTH(16)) dut32 (
        .clk_i (clk), .rst_i (rst), .bus (bus32), .mode_i (mode), .cnt_en_i (cnt_en),
        .priv_mask_i (priv_mask), .asid_flt_en_i (asid_flt_en), .asid_match_i (asid_match),
        .arm_i (arm), .clear_i (clear), .irq_en_i (irq_en), .state_o (state32),
        .ovf_o (ovf32), .irq_o (irq32)
    );

    spu_event_receiver #(.NUM_EVENTS(4), .CNT_WIDTH(4), .ASID_WIDTH(16)) dut4 (
        .clk_i (clk), .rst_i (rst), .bus (bus4), .mode_i (mode), .cnt_en_i (cnt_en),
        .priv_mask_i (priv_mask), .asid_flt_en_i (asid_flt_en), .asid_match_i (asid_match),
        .arm_i (arm), .clear_i (clear), .irq_en_i (irq_en), .state_o (state4),
        .ovf_o (ovf4), .irq_o (irq4)
    );

    localparam logic [1:0] PM = 2'b01, PS = 2'b10, PU = 2'b11, PI = 2'b00;

    typedef struct {
        logic [4:0]  id;
        logic [1:0]  priv;
        logic [15:0] asid;
        logic [2:0]  pmask;
        logic        aflt;
        logic [3:0]  en;
        int          n;
        logic [3:0]  addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [19:0] info(input logic [1:0] tag, input logic [1:0] priv,
                                         input logic [15:0] asid);
        return {tag, priv, asid};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] id, input logic [19:0] inf);
        e_id   = id;
        e_info = inf;
        step();
    endtask

    task automatic drain();
        e_id   = '0;
        e_info = '0;
        step();
        step();
    endtask

    task automatic rd(input logic [3:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req = 1'b0;
        rdat32 = bus32.rd_data_o;
        rdat4  = 32'(bus4.rd_data_o);
        rvld   = bus32.rd_valid_o;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
        rd(a);
        chk(nm, rdat32, exp);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; e_id = '0; e_info = '0; mode = 1'b0; asid_flt_en = 1'b0; arm = 1'b0;
        clear = 1'b0; rd_req = 1'b0; irq_en = 1'b0; cnt_en = 4'hF; rd_addr = '0;
        priv_mask = 3'b111; asid_match = 16'hABCD;

        //            id     priv asid      pmask   aflt en     n   addr  exp
        vecs[0]  = '{5'h01, PM, 16'h0000, 3'b111, 1'b0, 4'hF, 10, 4'd0,  32'd10};
        vecs[1]  = '{5'h01, PM, 16'h0000, 3'b111, 1'b0, 4'hF, 10, 4'd1,  32'd0};
        vecs[2]  = '{5'h02, PU, 16'h0000, 3'b100, 1'b0, 4'hF, 5,  4'd1,  32'd5};
        vecs[3]  = '{5'h02, PM, 16'h0000, 3'b100, 1'b0, 4'hF, 5,  4'd1,  32'd0};
        vecs[4]  = '{5'h02, PI, 16'h0000, 3'b111, 1'b0, 4'hF, 3,  4'd1,  32'd0};
        vecs[5]  = '{5'h08, PS, 16'h0000, 3'b010, 1'b0, 4'hF, 4,  4'd3,  32'd4};
        vecs[6]  = '{5'h04, PM, 16'h1234, 3'b111, 1'b1, 4'hF, 4,  4'd2,  32'd0};
        vecs[7]  = '{5'h04, PM, 16'hABCD, 3'b111, 1'b1, 4'hF, 6,  4'd2,  32'd6};
        vecs[8]  = '{5'h0F, PU, 16'h0000, 3'b111, 1'b0, 4'b0101, 3, 4'd2, 32'd3};
        vecs[9]  = '{5'h0F, PU, 16'h0000, 3'b111, 1'b0, 4'b0101, 3, 4'd1, 32'd0};
        vecs[10] = '{5'h01, PM, 16'h0000, 3'b001, 1'b0, 4'hF, 2,  4'd13, 32'd0};
        vecs[11] = '{5'h01, PS, 16'h0000, 3'b101, 1'b0, 4'hF, 7,  4'd0,  32'd0};

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_state", 32'(state32), 32'd0);
        chk("rst_ovf", 32'(ovf32), 32'd0);
        chk("rst_irq", 32'(irq32), 32'd0);
        chk("rst_rd_valid", 32'(bus32.rd_valid_o), 32'd0);
        chk("rst_rd_data", bus32.rd_data_o, 32'd0);
        rd_chk("rst_cnt0", 4'd0, 32'd0);
        chk("rd_valid", 32'(rvld), 32'd1);

        // Free-run filter vectors
        for (int i = 0; i < 12; i++) begin
            mode = 1'b0; priv_mask = vecs[i].pmask; asid_flt_en = vecs[i].aflt;
            cnt_en = vecs[i].en;
            pulse_clear();
            for (int k = 0; k < vecs[i].n; k++) beat(vecs[i].id, info(2'd0, vecs[i].priv, vecs[i].asid));
            drain();
            rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        priv_mask = 3'b111; asid_flt_en = 1'b0; cnt_en = 4'hF;

        // Mixed privilege stream on ev1 with only U allowed
        priv_mask = 3'b100;
        pulse_clear();
        for (int k = 0; k < 5; k++) beat(5'h02, info(2'd0, PU, 16'h0));
        for (int k = 0; k < 5; k++) beat(5'h02, info(2'd0, PM, 16'h0));
        for (int k = 0; k < 3; k++) beat(5'h02, info(2'd0, PI, 16'h0));
        drain();
        rd_chk("priv_mix_cnt1", 4'd1, 32'd5);
        priv_mask = 3'b111;

        // Window: events only between tag0 and tag1 beats (both inclusive)
        mode = 1'b1;
        pulse_clear();
        pulse_arm();
        chk("win_armed", 32'(state32), 32'd1);
        for (int k = 0; k < 3; k++) beat(5'h01, info(2'd0, PM, 16'h0));
        beat(5'h11, info(2'd0, PM, 16'h0));
        beat(5'h01, info(2'd0, PM, 16'h0));
        chk("win_run", 32'(state32), 32'd2);
        for (int k = 0; k < 3; k++) beat(5'h01, info(2'd0, PM, 16'h0));
        beat(5'h11, info(2'd1, PM, 16'h0));
        for (int k = 0; k < 6; k++) beat(5'h01, info(2'd0, PM, 16'h0));
        drain();
        rd_chk("win_cnt0", 4'd0, 32'd6);
        chk("win_done", 32'(state32), 32'd3);
        rd_chk("win_status", 4'd12, 32'd3);
        beat(5'h10, info(2'd0, PM, 16'h0));
        drain();
        chk("done_ignores_tag0", 32'(state32), 32'd3);

        // Snapshots in RUN
        pulse_clear();
        pulse_arm();
        beat(5'h11, info(2'd0, PM, 16'h0));
        for (int k = 0; k < 6; k++) beat(5'h01, info(2'd0, PM, 16'h0));
        beat(5'h11, info(2'd2, PM, 16'h0));
        for (int k = 0; k < 3; k++) beat(5'h01, info(2'd0, PM, 16'h0));
        beat(5'h11, info(2'd3, PM, 16'h0));
        drain();
        rd_chk("snap0_0", 4'd4, 32'd8);
        rd_chk("snap1_0", 4'd8, 32'd12);
        rd_chk("snap_cnt0", 4'd0, 32'd12);
        rd_chk("snap0_1", 4'd5, 32'd0);
        chk("snap_state", 32'(state32), 32'd2);
        pulse_arm();
        rd_chk("arm_keeps_snap", 4'd4, 32'd8);
        rd_chk("arm_clears_cnt", 4'd0, 32'd0);

        // Read coinciding with an increment returns the old value
        mode = 1'b0;
        pulse_clear();
        for (int k = 0; k < 3; k++) beat(5'h01, info(2'd0, PM, 16'h0));
        drain();
        beat(5'h01, info(2'd0, PM, 16'h0));
        e_id = '0;
        rd(4'd0);
        chk("rd_collide", rdat32, 32'd3);
        chk("rd_collide_vld", 32'(rvld), 32'd1);
        step();
        chk("rd_valid_drop", 32'(bus32.rd_valid_o), 32'd0);
        rd_chk("rd_after", 4'd0, 32'd4);

        // Clear coinciding with an increment wins
        beat(5'h01, info(2'd0, PM, 16'h0));
        e_id = '0;
        pulse_clear();
        drain();
        rd_chk("clear_collide", 4'd0, 32'd0);

        // Overflow on the 4-bit instance
        irq_en = 1'b1;
        pulse_clear();
        for (int k = 0; k < 17; k++) beat(5'h04, info(2'd0, PM, 16'h0));
        drain();
        rd(4'd2);
        chk("ovf_cnt2", rdat4, 32'd1);
        chk("ovf_flags", 32'(ovf4), 32'h4);
        chk("ovf_irq", 32'(irq4), 32'd1);
        chk("wide_no_ovf", 32'(ovf32), 32'd0);
        chk("wide_no_irq", 32'(irq32), 32'd0);
        rd_chk("wide_cnt2", 4'd2, 32'd17);
        pulse_clear();
        chk("ovf_cleared", 32'(ovf4), 32'd0);
        chk("irq_cleared", 32'(irq4), 32'd0);
        rd(4'd2);
        chk("ovf_cnt_cleared", rdat4, 32'd0);
        irq_en = 1'b0;

        // Reset in the middle of a window, with an event in flight
        mode = 1'b1;
        pulse_arm();
        beat(5'h11, info(2'd0, PM, 16'h0));
        for (int k = 0; k < 3; k++) beat(5'h01, info(2'd0, PM, 16'h0));
        chk("pre_rst_run", 32'(state32), 32'd2);
        e_id = 5'h01;
        rst  = 1'b1;
        mode = 1'b0;
        step();
        rst  = 1'b0;
        e_id = '0;
        chk("rst_mid_state", 32'(state32), 32'd0);
        drain();
        rd_chk("rst_mid_cnt0", 4'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
